// File: rtl/hbr_pkg.sv
// rtl/hbr_pkg.sv - shared state type, CA field positions and default constants for hyperbus_responder
package hbr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_READ,
    ST_WRITE,
    ST_REGWR
  } hbr_state_e;

  localparam int CA_RW_BIT    = 47;
  localparam int CA_AS_BIT    = 46;
  localparam int CA_BURST_BIT = 45;
  localparam int CA_ROW_MSB   = 44;
  localparam int CA_ROW_LSB   = 16;
  localparam int CA_COL_MSB   = 2;
  localparam int CA_ROW_W     = CA_ROW_MSB - CA_ROW_LSB + 1;

  localparam logic [15:0] HBR_ID0_VAL   = 16'h0C81;
  localparam logic [15:0] HBR_CR0_RESET = 16'h8F1F;

endpackage

// File: rtl/hbr_mem.sv
// rtl/hbr_mem.sv - single-port 16-bit word array with write enable and registered read
module hbr_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       wdata_i,
  output logic [15:0]       rdata_o
);

  logic [15:0] mem_q [2**ADDR_W];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/hyperbus_responder.sv
// rtl/hyperbus_responder.sv - HyperBus-style memory responder; HYPERBUS_RESPONDER_REGWR_EN enables CR0 writes
module hyperbus_responder
  import hbr_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          LATENCY     = 14,
  parameter int          BURST_WORDS = 16,
  parameter logic [15:0] ID0_VAL     = HBR_ID0_VAL,
  parameter logic [15:0] CR0_RESET   = HBR_CR0_RESET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csn,
  input  logic        ck_en,
  input  logic [15:0] dq_in,
  input  logic        rwds_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        rwds_out,
  output logic        rwds_oe,
  output logic [15:0] cr0,
  output logic        busy
);

  localparam int                LAT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'(BURST_WORDS - 1);

  hbr_state_e            state_q;
  logic [1:0]            ca_cnt_q;
  logic                  rw_q;
  logic                  as_q;
  logic                  lin_q;
  logic [CA_ROW_W-1:0]   row_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [LAT_W-1:0]      lat_cnt_q;
  logic [15:0]           dq_out_q;
  logic                  dq_oe_q;
  logic                  rwds_out_q;
  logic                  rwds_oe_q;
  logic                  busy_q;
  logic [15:0]           reg_rd_q;

  logic [ADDR_W-1:0]     addr_inc;
  logic [ADDR_W-1:0]     addr_d;
  logic [15:0]           mem_rdata;
  logic                  mem_we;

  assign addr_inc = addr_q + ADDR_W'(1);
  assign addr_d   = lin_q ? addr_inc : ((addr_q & ~WRAP_MASK) | (addr_inc & WRAP_MASK));

  // An edge that aborts or resets must never land a write word.
  assign mem_we = (state_q == ST_WRITE) && ck_en && !rwds_in && !csn && !rst;

  hbr_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (addr_q),
    .wdata_i (dq_in),
    .rdata_o (mem_rdata)
  );

  // Register-space read data, pipelined to line up with the array's registered read.
  always_ff @(posedge clk) begin
    reg_rd_q <= (addr_q == '0) ? ID0_VAL : cr0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ca_cnt_q   <= '0;
      rw_q       <= 1'b0;
      as_q       <= 1'b0;
      lin_q      <= 1'b0;
      row_q      <= '0;
      addr_q     <= '0;
      lat_cnt_q  <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      rwds_out_q <= 1'b0;
      rwds_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else if (csn) begin
      state_q    <= ST_IDLE;
      ca_cnt_q   <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      rwds_out_q <= 1'b0;
      rwds_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q    <= ST_CA;
          ca_cnt_q   <= '0;
          rwds_out_q <= 1'b1;
          rwds_oe_q  <= 1'b1;
          busy_q     <= 1'b1;
        end
        ST_CA: begin
          if (ck_en) begin
            ca_cnt_q <= ca_cnt_q + 2'd1;
            if (ca_cnt_q == 2'd0) begin
              rw_q                  <= dq_in[CA_RW_BIT-32];
              as_q                  <= dq_in[CA_AS_BIT-32];
              lin_q                 <= dq_in[CA_BURST_BIT-32];
              row_q[CA_ROW_W-1:16]  <= dq_in[CA_ROW_W-17:0];
            end else if (ca_cnt_q == 2'd1) begin
              row_q[15:0] <= dq_in;
            end else begin
              addr_q     <= ADDR_W'({row_q, dq_in[CA_COL_MSB:0]});
              lat_cnt_q  <= '0;
              rwds_out_q <= 1'b0;
              rwds_oe_q  <= 1'b0;
              state_q    <= (!rw_q && as_q) ? ST_REGWR : ST_LAT;
            end
          end
        end
        ST_LAT: begin
          if (lat_cnt_q == LAT_LAST) begin
            state_q <= rw_q ? ST_READ : ST_WRITE;
            // The array was read at the start address on this edge; step past it.
            if (rw_q) addr_q <= addr_d;
          end else begin
            lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          end
        end
        ST_READ: begin
          dq_out_q   <= as_q ? reg_rd_q : mem_rdata;
          dq_oe_q    <= 1'b1;
          rwds_out_q <= 1'b1;
          rwds_oe_q  <= 1'b1;
          addr_q     <= addr_d;
        end
        ST_WRITE: begin
          if (ck_en) addr_q <= addr_d;
        end
        ST_REGWR: begin
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef HYPERBUS_RESPONDER_REGWR_EN
  logic [15:0] cr0_q;
  logic        regwr_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr0_q        <= CR0_RESET;
      regwr_done_q <= 1'b0;
    end else if (state_q != ST_REGWR) begin
      regwr_done_q <= 1'b0;
    end else if (ck_en && !csn) begin
      if (!regwr_done_q) cr0_q <= dq_in;
      regwr_done_q <= 1'b1;
    end
  end

  assign cr0 = cr0_q;
`else
  assign cr0 = CR0_RESET;
`endif

  assign dq_out   = dq_out_q;
  assign dq_oe    = dq_oe_q;
  assign rwds_out = rwds_out_q;
  assign rwds_oe  = rwds_oe_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_hyperbus_responder.sv
// tb/tb_hyperbus_responder.sv - scoreboard bench for hyperbus_responder
module tb_hyperbus_responder;

  localparam int LATENCY = 14;
`ifdef HYPERBUS_RESPONDER_REGWR_EN
  localparam logic [15:0] CR0_EXP = 16'h8F17;
`else
  localparam logic [15:0] CR0_EXP = 16'h8F1F;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csn = 1'b1;
  logic        ck_en = 1'b0;
  logic [15:0] dq_in = '0;
  logic        rwds_in = 1'b0;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        rwds_out;
  logic        rwds_oe;
  logic [15:0] cr0;
  logic        busy;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] sb_q[$];
  logic [15:0] wr_d[$];
  logic        wr_m[$];

  hyperbus_responder #(
    .ADDR_W      (10),
    .LATENCY     (LATENCY),
    .BURST_WORDS (16),
    .ID0_VAL     (16'h0C81),
    .CR0_RESET   (16'h8F1F)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .csn      (csn),
    .ck_en    (ck_en),
    .dq_in    (dq_in),
    .rwds_in  (rwds_in),
    .dq_out   (dq_out),
    .dq_oe    (dq_oe),
    .rwds_out (rwds_out),
    .rwds_oe  (rwds_oe),
    .cr0      (cr0),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic e, input logic [15:0] d, input logic m);
    csn = c; ck_en = e; dq_in = d; rwds_in = m;
    @(posedge clk); #1;
  endtask

  task automatic start_cmd(input logic [47:0] ca);
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    check("ca_ready", {29'd0, rwds_out, rwds_oe, busy}, 32'd7);
    cyc(1'b0, 1'b1, ca[47:32], 1'b0);
    cyc(1'b0, 1'b1, ca[31:16], 1'b0);
    cyc(1'b0, 1'b1, ca[15:0], 1'b0);
  endtask

  task automatic end_cmd();
    cyc(1'b1, 1'b0, 16'h0, 1'b0);
    check("idle_after", {28'd0, dq_oe, rwds_oe, rwds_out, busy}, 32'd0);
  endtask

  task automatic do_read(input logic [47:0] ca, input string tag);
    int n;
    int got;
    logic [15:0] exp;
    n = sb_q.size();
    got = 0;
    start_cmd(ca);
    for (int k = 1; (k <= LATENCY + n + 4) && (got < n); k++) begin
      cyc(1'b0, 1'b0, 16'h0, 1'b0);
      if (dq_oe) begin
        if (got == 0) begin
          check({tag, "_lat"}, k, LATENCY + 1);
          check({tag, "_strobe"}, {31'd0, rwds_out}, 32'd1);
        end
        exp = sb_q.pop_front();
        check(tag, {16'd0, dq_out}, {16'd0, exp});
        got++;
      end
    end
    if (got < n) check({tag, "_timeout"}, got, n);
    sb_q.delete();
    end_cmd();
  endtask

  task automatic do_write(input logic [47:0] ca);
    start_cmd(ca);
    for (int k = 0; k < LATENCY; k++) cyc(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < wr_d.size(); i++) begin
      if (i == 1) cyc(1'b0, 1'b0, 16'hDEAD, 1'b0);
      cyc(1'b0, 1'b1, wr_d[i], wr_m[i]);
    end
    wr_d.delete();
    wr_m.delete();
    end_cmd();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) cyc(1'b1, 1'b0, 16'h0, 1'b0);
    check("rst_dq_out", {16'd0, dq_out}, 32'd0);
    check("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
    check("rst_rwds_out", {31'd0, rwds_out}, 32'd0);
    check("rst_rwds_oe", {31'd0, rwds_oe}, 32'd0);
    check("rst_cr0", {16'd0, cr0}, 32'h8F1F);
    check("rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 32; i++) begin
      wr_d.push_back(16'h5000 + 16'(i));
      wr_m.push_back(1'b0);
    end
    do_write(48'h2000_0000_0000);

    wr_d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    wr_m = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_write(48'h2000_0001_0000);
    sb_q = '{16'h1111, 16'h2222, 16'h500A, 16'h4444};
    do_read(48'hA000_0001_0000, "lin_rd");

    sb_q = '{16'h500E, 16'h500F, 16'h5000, 16'h5001};
    do_read(48'h8000_0001_0006, "wrap_rd");

    sb_q = '{16'h0C81};
    do_read(48'hC000_0000_0000, "id0_rd");

    start_cmd(48'h6000_0100_0000);
    cyc(1'b0, 1'b1, 16'h8F17, 1'b0);
    check("regwr_rwds_oe", {31'd0, rwds_oe}, 32'd0);
    cyc(1'b0, 1'b1, 16'h1234, 1'b0);
    end_cmd();
    check("regwr_cr0", {16'd0, cr0}, {16'd0, CR0_EXP});
    sb_q = '{CR0_EXP};
    do_read(48'hC000_0000_0001, "cr0_rd");

    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 16'h2000, 1'b0);
    cyc(1'b0, 1'b1, 16'h0001, 1'b0);
    end_cmd();
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 16'h2000, 1'b0);
    cyc(1'b0, 1'b1, 16'h0001, 1'b0);
    cyc(1'b1, 1'b1, 16'h0000, 1'b0);
    check("abort_last_ca", {30'd0, rwds_oe, busy}, 32'd0);
    repeat (LATENCY + 3) cyc(1'b1, 1'b1, 16'hBAD0, 1'b0);
    sb_q = '{16'h1111, 16'h2222};
    do_read(48'hA000_0001_0000, "post_abort_rd");

    start_cmd(48'h2000_0002_0004);
    for (int k = 0; k < LATENCY; k++) cyc(1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 16'hBEEF, 1'b0);
    csn = 1'b0; ck_en = 1'b1; dq_in = 16'hDEAD; rwds_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_cr0", {16'd0, cr0}, 32'h8F1F);
    check("midrst_outs", {29'd0, dq_oe, rwds_oe, rwds_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) cyc(1'b1, 1'b0, 16'h0, 1'b0);
    sb_q = '{16'hBEEF, 16'h5015};
    do_read(48'hA000_0002_0004, "post_rst_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hyperbus_responder.md
# hyperbus_responder

Synthesizable HyperBus-style memory responder: the device end of the controller state machines (register read, memory read, memory write). It samples chip select, captures the 48-bit command/address (CA) as three 16-bit words, and signals readiness and latency on RWDS. It then serves read bursts from, or accepts masked write bursts into, an internal word array. It sits in the FPGA loopback testbench, and in on-chip bring-up builds, in place of the external HyperRAM.

## Interface
- `ADDR_W`, 10: word-address width; array depth is 2**ADDR_W words.
- `LATENCY`, 14: clk cycles from the last CA word to the first data word.
- `BURST_WORDS`, 16: wrap length for wrapped bursts; must be a power of two.
- `ID0_VAL`, 16'h0C81: value returned on register reads at address 0.
- `CR0_RESET`, 16'h8F1F: reset value of CR0.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `csn` in 1: chip select, active low.
- `ck_en` in 1: controller bus-clock enable; qualifies CA and write words.
- `dq_in` in 16: word driven by the controller.
- `rwds_in` in 1: write mask; 1 means the current write word is discarded.
- `dq_out` out 16: read data.
- `dq_oe` out 1: responder drives DQ.
- `rwds_out` out 1: ready/strobe.
- `rwds_oe` out 1: responder drives RWDS.
- `cr0` out 16: current configuration register.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, CA, LAT, READ, WRITE, REGWR.
- IDLE → CA when `csn` is sampled low.
- In CA, `rwds_oe` = 1 and `rwds_out` = 1, which is the ready indication the controller waits for.
- In CA, one word is captured per edge with `ck_en` = 1, in the order CA[47:32], CA[31:16], CA[15:0].
- CA decode:
  - CA[47] = 1 means read.
  - CA[46] = 1 means register space.
  - CA[45] = 0 means wrapped burst; 1 means linear.
  - Word address = {CA[44:16], CA[2:0]}, truncated to `ADDR_W` bits.
- After the third CA word:
  - Register write → REGWR.
  - Every other command → LAT.
- REGWR: the first `ck_en` word is written to `cr0`. Later words are ignored. No RWDS drive.
- LAT: counts `LATENCY` clk cycles, regardless of `ck_en`. `rwds_out` = 0, `rwds_oe` = 0. Exits to READ (read) or WRITE (write).
- READ: every cycle `dq_oe` = 1 and `rwds_out` = 1 (strobe) with `rwds_oe` = 1. `dq_out` = array[addr], then addr advances.
- Register read data: `ID0_VAL` when the address is 0, otherwise `cr0`.
- WRITE: on each `ck_en` edge, `dq_in` is written to array[addr] only if `rwds_in` = 0. Addr advances whether or not the word is written.
- Address advance:
  - Linear burst: increments and wraps at 2**`ADDR_W`.
  - Wrapped burst: low log2(`BURST_WORDS`) bits increment modulo `BURST_WORDS`; upper bits are held.
- Burst length is unbounded and ends only when `csn` rises.

## Timing
- Reset values: `dq_out` 0, `dq_oe` 0, `rwds_out` 0, `rwds_oe` 0, `cr0` = `CR0_RESET`, `busy` 0, state IDLE. The array is not reset.
- `csn` low sampled at edge T0:
  - state = CA and `rwds_out` = `rwds_oe` = 1 after T0.
  - `busy` = 1 after T0.
- Third CA word at edge Tc:
  - First read word is valid on `dq_out` after edge Tc+`LATENCY`+1.
  - The array read is prefetched in the last LAT cycle, so there are no bubbles.
  - Later read words follow every cycle.
- `csn` sampled high in any state, including mid-CA or mid-burst:
  - Next state is IDLE.
  - `dq_oe`, `rwds_oe`, `rwds_out` go to 0 at the same edge.
  - Partial CA is discarded; writes already performed are kept.
- `ck_en` low in CA or WRITE stalls capture and address advance. It does not stall the LAT count or READ.
- `csn` rising on the same edge as the last CA word: abort wins, no command executes.
- `rst` asserted mid-burst: outputs take reset values immediately (asynchronously). The in-flight write word is not written.

## Configuration
- `HYPERBUS_RESPONDER_REGWR_EN` defined: register writes update `cr0` as described.
- Macro not defined:
  - REGWR still consumes words, but `cr0` stays at `CR0_RESET`.
  - `cr0` is implemented as a constant, with no flops.

## Structure
- `hbr_pkg` holds:
  - the state enum `hbr_state_e`;
  - CA field bit-position localparams (RW, AS, BURST, row MSB/LSB, column bits);
  - default `ID0_VAL` and `CR0_RESET` constants.
- Sub-module `hbr_mem`: single-port synchronous RAM, `ADDR_W` × 16, with write enable and registered read. The top block instantiates it once.

## Test plan
- Reset, then hold `csn` high for 10 cycles → all outputs 0, `cr0` = 16'h8F1F, `busy` 0.
- Linear write of 4 words 16'h1111–16'h4444 to word address 8, with `rwds_in` = 1 on the 3rd word, followed by a linear read of 4 words from address 8 → 16'h1111, 16'h2222, old value, 16'h4444. The first read word appears `LATENCY`+1 cycles after the last CA word.
- Wrapped read starting at address 14, 4 words, with `BURST_WORDS` = 16 → addresses 14, 15, 0, 1.
- Register read, CA = 48'hC000_0000_0000 → `dq_out` = 16'h0C81.
- Register write of 16'h8F17 to CR0, then a register read at address 1 → 16'h8F17 with the macro defined, 16'h8F1F without it.
- `csn` deasserted after the 2nd CA word, then a normal read → first transaction has no effect, second returns correct data; `rst` pulsed mid-write clears outputs within the same cycle.
